// File: rtl/clock_divider_controller.sv
// Runtime-programmable clock divider: ratio and run/stop changes are deferred to the
// end of the current clk_out period so the derived clock never glitches or truncates.
module clock_divider_controller #(
    parameter int DIV_WIDTH     = 16,
    parameter int RESET_DIVIDER = 10
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DIV_WIDTH-1:0] cfg_divider,
    input  logic                 cfg_enable,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 busy,
    output logic                 cfg_error,
    output logic [DIV_WIDTH-1:0] active_divider,
    output logic                 running
);

    typedef enum logic [1:0] {
        STOP,
        RUN,
        PEND
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pendDiv_q, pendDiv_d;
    logic                 pendEn_q, pendEn_d;
    logic                 primed_q, primed_d;
    logic                 clkOut_q, clkOut_d;
    logic                 tick_q, tick_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;

    logic accept;
    logic invalid;
    logic lastCycle;
    logic runNext;

    assign accept    = cfg_valid && ready_q;
    assign invalid   = cfg_enable && (cfg_divider < DIV_WIDTH'(2));
    assign lastCycle = (cnt_q == (div_q - DIV_WIDTH'(1)));

    // cnt_q is the position of the cycle currently shown on clk_out; primed_q marks the
    // first cycle after reset, which shows position 0 without advancing the counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pendDiv_d = pendDiv_q;
        pendEn_d  = pendEn_q;
        primed_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            STOP: begin
                cnt_d = '0;
                if (accept) begin
                    if (invalid) begin
                        err_d = 1'b1;
                    end else if (cfg_enable) begin
                        state_d = RUN;
                        div_d   = cfg_divider;
                    end
                end
            end
            RUN, PEND: begin
                if (primed_q || lastCycle) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
                if (state_q == RUN) begin
                    if (accept) begin
                        if (invalid) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = PEND;
                            pendDiv_d = cfg_divider;
                            pendEn_d  = cfg_enable;
                        end
                    end
                end else if (!primed_q && lastCycle) begin
                    // Change lands only on the edge closing the last low cycle.
                    if (pendEn_q) begin
                        div_d   = pendDiv_q;
                        state_d = RUN;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        runNext  = (state_d != STOP);
        clkOut_d = runNext && (cnt_d < (div_d >> 1));
        tick_d   = runNext && (cnt_d == '0);
        ready_d  = (state_d != PEND);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            div_q     <= DIV_WIDTH'(RESET_DIVIDER);
            pendDiv_q <= '0;
            pendEn_q  <= 1'b0;
            primed_q  <= 1'b1;
            clkOut_q  <= 1'b0;
            tick_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pendDiv_q <= pendDiv_d;
            pendEn_q  <= pendEn_d;
            primed_q  <= primed_d;
            clkOut_q  <= clkOut_d;
            tick_q    <= tick_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign clk_out        = clkOut_q;
    assign tick           = tick_q;
    assign cfg_ready      = ready_q;
    assign cfg_error      = err_q;
    assign busy           = (state_q == PEND);
    assign running        = (state_q != STOP);
    assign active_divider = div_q;

endmodule

// File: tb/tb_clock_divider_controller.sv
// Directed bench for clock_divider_controller: walks through ratio changes, stop/start,
// invalid requests, back-to-back requests and reset during a pending change.
module tb_clock_divider_controller;

    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_divider;
    logic          cfg_enable;
    logic          clk_out;
    logic          tick;
    logic          busy;
    logic          cfg_error;
    logic [DW-1:0] active_divider;
    logic          running;

    int checks = 0;
    int errors = 0;

    clock_divider_controller #(.DIV_WIDTH(DW), .RESET_DIVIDER(10)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_divider   (cfg_divider),
        .cfg_enable    (cfg_enable),
        .clk_out       (clk_out),
        .tick          (tick),
        .busy          (busy),
        .cfg_error     (cfg_error),
        .active_divider(active_divider),
        .running       (running)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] div, input logic en);
        cfg_valid   = valid;
        cfg_divider = div;
        cfg_enable  = en;
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic stepCycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic expectCycle(input int d, input int p);
        checkOutput($sformatf("clk_out D%0d p%0d", d, p), {31'd0, clk_out}, (p < (d >> 1)) ? 32'd1 : 32'd0);
        checkOutput($sformatf("tick D%0d p%0d", d, p), {31'd0, tick}, (p == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic runPeriod(input int d, input int from, input int upto);
        for (int p = from; p <= upto; p++) begin
            stepCycle();
            expectCycle(d, p);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rst clk_out", {31'd0, clk_out}, 32'd0);
        checkOutput("rst tick", {31'd0, tick}, 32'd0);
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst ready", {31'd0, cfg_ready}, 32'd0);
        checkOutput("rst active", {16'd0, active_divider}, 32'd10);
        checkOutput("rst running", {31'd0, running}, 32'd1);

        // Default D=10: 5 high / 5 low
        reset = 1'b0;
        stepCycle();
        expectCycle(10, 0);
        checkOutput("rel ready", {31'd0, cfg_ready}, 32'd1);
        runPeriod(10, 1, 9);
        runPeriod(10, 0, 2);

        // Divider 4 requested at cnt=2; old period completes first
        applyStimulus(1'b1, 16'd4, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(10, 3);
        checkOutput("pend busy", {31'd0, busy}, 32'd1);
        checkOutput("pend ready", {31'd0, cfg_ready}, 32'd0);
        runPeriod(10, 4, 9);
        checkOutput("pend busy p9", {31'd0, busy}, 32'd1);
        checkOutput("pend active p9", {16'd0, active_divider}, 32'd10);
        stepCycle();
        expectCycle(4, 0);
        checkOutput("d4 active", {16'd0, active_divider}, 32'd4);
        checkOutput("d4 busy", {31'd0, busy}, 32'd0);
        checkOutput("d4 ready", {31'd0, cfg_ready}, 32'd1);
        runPeriod(4, 1, 3);
        runPeriod(4, 0, 0);

        // Invalid dividers 1 and 0 with enable
        applyStimulus(1'b1, 16'd1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(4, 1);
        checkOutput("err1 pulse", {31'd0, cfg_error}, 32'd1);
        checkOutput("err1 active", {16'd0, active_divider}, 32'd4);
        checkOutput("err1 busy", {31'd0, busy}, 32'd0);
        stepCycle();
        expectCycle(4, 2);
        checkOutput("err1 clear", {31'd0, cfg_error}, 32'd0);
        checkOutput("err1 ready", {31'd0, cfg_ready}, 32'd1);
        applyStimulus(1'b1, 16'd0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(4, 3);
        checkOutput("err0 pulse", {31'd0, cfg_error}, 32'd1);
        stepCycle();
        expectCycle(4, 0);
        checkOutput("err0 clear", {31'd0, cfg_error}, 32'd0);
        checkOutput("err0 active", {16'd0, active_divider}, 32'd4);

        // Back to D=10, then stop mid high phase
        applyStimulus(1'b1, 16'd10, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(4, 1);
        runPeriod(4, 2, 3);
        runPeriod(10, 0, 1);
        applyStimulus(1'b1, 16'd0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(10, 2);
        checkOutput("stop err", {31'd0, cfg_error}, 32'd0);
        checkOutput("stop busy", {31'd0, busy}, 32'd1);
        runPeriod(10, 3, 9);
        checkOutput("stop running p9", {31'd0, running}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("stopped clk_out %0d", i), {31'd0, clk_out}, 32'd0);
            checkOutput($sformatf("stopped tick %0d", i), {31'd0, tick}, 32'd0);
            checkOutput($sformatf("stopped running %0d", i), {31'd0, running}, 32'd0);
            checkOutput($sformatf("stopped ready %0d", i), {31'd0, cfg_ready}, 32'd1);
        end

        // Start from STOP with D=7: 3 high / 4 low
        applyStimulus(1'b1, 16'd7, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(7, 0);
        checkOutput("start running", {31'd0, running}, 32'd1);
        checkOutput("start active", {16'd0, active_divider}, 32'd7);
        runPeriod(7, 1, 6);
        runPeriod(7, 0, 0);

        // Back-to-back D=6 then D=8 with cfg_valid held
        applyStimulus(1'b1, 16'd6, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 16'd8, 1'b1);
        expectCycle(7, 1);
        checkOutput("b2b ready p1", {31'd0, cfg_ready}, 32'd0);
        runPeriod(7, 2, 6);
        checkOutput("b2b ready p6", {31'd0, cfg_ready}, 32'd0);
        stepCycle();
        expectCycle(6, 0);
        checkOutput("b2b active6", {16'd0, active_divider}, 32'd6);
        checkOutput("b2b ready6", {31'd0, cfg_ready}, 32'd1);
        checkOutput("b2b busy6", {31'd0, busy}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(6, 1);
        checkOutput("b2b busy8", {31'd0, busy}, 32'd1);
        runPeriod(6, 2, 5);
        runPeriod(8, 0, 0);
        checkOutput("b2b active8", {16'd0, active_divider}, 32'd8);
        runPeriod(8, 1, 7);
        runPeriod(8, 0, 0);

        // Reset while a change is pending
        applyStimulus(1'b1, 16'd4, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rstpend busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        stepCycle();
        checkOutput("rstpend clk_out", {31'd0, clk_out}, 32'd0);
        checkOutput("rstpend busy0", {31'd0, busy}, 32'd0);
        checkOutput("rstpend ready", {31'd0, cfg_ready}, 32'd0);
        checkOutput("rstpend active", {16'd0, active_divider}, 32'd10);
        reset = 1'b0;
        stepCycle();
        expectCycle(10, 0);
        runPeriod(10, 1, 9);
        checkOutput("rstpend discarded", {16'd0, active_divider}, 32'd10);

        // Minimum divider D=2
        stepCycle();
        expectCycle(10, 0);
        applyStimulus(1'b1, 16'd2, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(10, 1);
        runPeriod(10, 2, 9);
        runPeriod(2, 0, 1);
        runPeriod(2, 0, 1);
        checkOutput("d2 active", {16'd0, active_divider}, 32'd2);

        // Maximum divider: first cycles of the new period
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0);
        expectCycle(2, 0);
        stepCycle();
        expectCycle(2, 1);
        runPeriod(65535, 0, 3);
        checkOutput("dmax active", {16'd0, active_divider}, 32'd65535);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
